// File: rtl/clause_vote_accum.sv
// clause_vote_accum: Tsetlin-style clause vote accumulator.
// Holds a CLAUSEN x CLASSN signed weight table. For each inference it adds the
// weights of fired clauses into saturating per-class sums. It then scans the
// sums for the winning class and presents the result with a one-cycle strobe.
module clause_vote_accum #(
  parameter int CLAUSEN  = 10,
  parameter int CLASSN   = 5,
  parameter int WEIGHT_W = 8,
  parameter int SUM_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                img_rst,
  input  logic                start,
  input  logic                w_valid,
  input  logic [7:0]          w_clause,
  input  logic [2:0]          w_class,
  input  logic [WEIGHT_W-1:0] w_data,
  input  logic                clause_done,
  input  logic                clause_op,
  output logic                busy,
  output logic                class_valid,
  output logic [2:0]          class_out,
  output logic [SUM_W-1:0]    class_sum
);

  localparam int CNT_W  = (CLAUSEN > 1) ? $clog2(CLAUSEN) : 1;
  localparam int SCAN_W = (CLASSN > 1) ? $clog2(CLASSN) : 1;
  // One guard bit above the wider operand, so a single add cannot wrap.
  localparam int ADD_W  = ((SUM_W > WEIGHT_W) ? SUM_W : WEIGHT_W) + 1;

  localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(CLAUSEN - 1);
  localparam logic [SCAN_W-1:0]       LAST_SCAN = SCAN_W'(CLASSN - 1);
  localparam logic signed [SUM_W-1:0] SUM_MAX   = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN   = {1'b1, {(SUM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t                     state;
  logic signed [WEIGHT_W-1:0] weight   [CLAUSEN][CLASSN];
  logic signed [SUM_W-1:0]    sums     [CLASSN];
  logic signed [ADD_W-1:0]    sum_raw  [CLASSN];
  logic signed [SUM_W-1:0]    sum_next [CLASSN];
  logic [CNT_W-1:0]           cnt;
  logic                       clause_done_q;
  logic                       clause_edge;
  logic [SCAN_W-1:0]          scan_idx;
  logic [SCAN_W-1:0]          best_idx;
  logic signed [SUM_W-1:0]    best_sum;
  logic [SCAN_W-1:0]          nb_idx;
  logic signed [SUM_W-1:0]    nb_sum;
  logic signed [SUM_W-1:0]    scan_sum;

  // A clause is offered only on a 0->1 transition of the done level.
  assign clause_edge = clause_done & ~clause_done_q;

  // Weight table: written only while idle, out-of-range indices fall through.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is built from flops, so a full reset is legal here;
      // the same table mapped to a RAM macro could not be cleared this way.
      for (int k = 0; k < CLAUSEN; k++) begin
        for (int c = 0; c < CLASSN; c++) begin
          weight[k][c] <= '0;
        end
      end
    end else if (!img_rst && w_valid && state == S_IDLE) begin
      for (int k = 0; k < CLAUSEN; k++) begin
        for (int c = 0; c < CLASSN; c++) begin
          if (w_clause == 8'(k) && w_class == 3'(c)) begin
            weight[k][c] <= w_data;
          end
        end
      end
    end
  end

  // Saturating candidate sums for the clause currently pointed to by cnt.
  always_comb begin
    for (int c = 0; c < CLASSN; c++) begin
      // NOTE: every output of this block is assigned on every path; a missing
      // branch would silently infer a latch.
      sum_raw[c] = {{(ADD_W-SUM_W){sums[c][SUM_W-1]}}, sums[c]}
                 + {{(ADD_W-WEIGHT_W){weight[cnt][c][WEIGHT_W-1]}}, weight[cnt][c]};
      if (sum_raw[c][ADD_W-1:SUM_W-1] == {(ADD_W-SUM_W+1){sum_raw[c][ADD_W-1]}}) begin
        sum_next[c] = sum_raw[c][SUM_W-1:0];
      end else if (sum_raw[c][ADD_W-1]) begin
        sum_next[c] = SUM_MIN;
      end else begin
        sum_next[c] = SUM_MAX;
      end
    end
  end

  // One argmax step: class 0 seeds the best, later classes win only if strictly greater.
  always_comb begin
    scan_sum = sums[scan_idx];
    nb_idx   = best_idx;
    nb_sum   = best_sum;
    if (scan_idx == '0) begin
      nb_idx = '0;
      nb_sum = scan_sum;
    end else if (scan_sum > best_sum) begin
      nb_idx = scan_idx;
      nb_sum = scan_sum;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      state         <= S_IDLE;
      for (int c = 0; c < CLASSN; c++) begin
        sums[c] <= '0;
      end
      cnt           <= '0;
      clause_done_q <= 1'b0;
      scan_idx      <= '0;
      best_idx      <= '0;
      best_sum      <= '0;
      busy          <= 1'b0;
      class_valid   <= 1'b0;
      class_out     <= '0;
      class_sum     <= '0;
    end else if (img_rst) begin
      // Abort the current image; weights and the last result survive.
      state         <= S_IDLE;
      for (int c = 0; c < CLASSN; c++) begin
        sums[c] <= '0;
      end
      cnt           <= '0;
      clause_done_q <= 1'b0;
      scan_idx      <= '0;
      busy          <= 1'b0;
      class_valid   <= 1'b0;
    end else begin
      clause_done_q <= clause_done;
      class_valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int c = 0; c < CLASSN; c++) begin
              sums[c] <= '0;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (clause_edge) begin
            if (clause_op) begin
              for (int c = 0; c < CLASSN; c++) begin
                sums[c] <= sum_next[c];
              end
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              scan_idx <= '0;
              state    <= S_ARGMAX;
            end
          end
        end
        S_ARGMAX: begin
          best_idx <= nb_idx;
          best_sum <= nb_sum;
          if (scan_idx == LAST_SCAN) begin
            busy        <= 1'b0;
            class_valid <= 1'b1;
            class_out   <= 3'(nb_idx);
            class_sum   <= nb_sum;
            state       <= S_DONE;
          end else begin
            scan_idx <= scan_idx + SCAN_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_vote_accum.sv
// Testbench for clause_vote_accum. Two instances share all stimulus: one with
// default widths and one with an 8-bit class sum, for saturation coverage.
// Expected winners come from a plain-arithmetic model of the vote rules.
module tb_clause_vote_accum;

  localparam int NCL = 10;
  localparam int NCS = 5;

  logic        clk = 1'b0;
  logic        rst, img_rst, start, w_valid, clause_done, clause_op;
  logic [7:0]  w_clause;
  logic [2:0]  w_class;
  logic [7:0]  w_data;

  logic        busy16, cv16, busy8, cv8;
  logic [2:0]  co16, co8;
  logic [15:0] cs16;
  logic [7:0]  cs8;

  int checks = 0;
  int errors = 0;
  int wm [NCL][NCS];

  clause_vote_accum #(.CLAUSEN(NCL), .CLASSN(NCS), .WEIGHT_W(8), .SUM_W(16)) dut16 (
    .clk(clk), .rst(rst), .img_rst(img_rst), .start(start), .w_valid(w_valid),
    .w_clause(w_clause), .w_class(w_class), .w_data(w_data),
    .clause_done(clause_done), .clause_op(clause_op),
    .busy(busy16), .class_valid(cv16), .class_out(co16), .class_sum(cs16));

  clause_vote_accum #(.CLAUSEN(NCL), .CLASSN(NCS), .WEIGHT_W(8), .SUM_W(8)) dut8 (
    .clk(clk), .rst(rst), .img_rst(img_rst), .start(start), .w_valid(w_valid),
    .w_clause(w_clause), .w_class(w_class), .w_data(w_data),
    .clause_done(clause_done), .clause_op(clause_op),
    .busy(busy8), .class_valid(cv8), .class_out(co8), .class_sum(cs8));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp(input int v, input int sw);
    int hi, lo;
    hi = (1 << (sw - 1)) - 1;
    lo = -(1 << (sw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model_result(input logic [NCL-1:0] fire, input int sw,
                                       output int idx, output int best);
    int s [NCS];
    for (int c = 0; c < NCS; c++) s[c] = 0;
    for (int k = 0; k < NCL; k++)
      if (fire[k])
        for (int c = 0; c < NCS; c++) s[c] = clamp(s[c] + wm[k][c], sw);
    idx  = 0;
    best = s[0];
    for (int c = 1; c < NCS; c++)
      if (s[c] > best) begin
        idx  = c;
        best = s[c];
      end
  endfunction

  task automatic write_w(input int k, input int c, input int v);
    w_valid  = 1'b1;
    w_clause = k[7:0];
    w_class  = c[2:0];
    w_data   = v[7:0];
    tick();
    w_valid  = 1'b0;
    if (k < NCL && c < NCS) wm[k][c] = v;
  endtask

  task automatic fill_w(input int v);
    for (int k = 0; k < NCL; k++)
      for (int c = 0; c < NCS; c++) write_w(k, c, v);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NCL; k++)
      for (int c = 0; c < NCS; c++) wm[k][c] = 0;
  endtask

  // Full inference with checks on latency, result, strobe width and output hold.
  task automatic run_inference(input string name, input logic [NCL-1:0] fire,
                               input int hold_first, input bit start_edge,
                               input bit mid_noise);
    int ei16, es16, ei8, es8, early, lat;
    model_result(fire, 16, ei16, es16);
    model_result(fire, 8, ei8, es8);
    early = 0;
    start = 1'b1;
    clause_done = start_edge;
    clause_op = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy16 !== 1'b1 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b/%b expected 1", name, busy16, busy8);
    end
    if (start_edge) begin
      tick();
      clause_done = 1'b0;
      tick();
    end
    for (int k = 0; k < NCL; k++) begin
      clause_op   = fire[k];
      clause_done = 1'b1;
      if (k == 0 && hold_first > 0) begin
        repeat (hold_first) begin
          tick();
          if (cv16 || cv8) early++;
        end
      end else begin
        tick();
      end
      if (k != NCL - 1) begin
        clause_done = 1'b0;
        clause_op   = 1'($urandom);
        if (mid_noise && k == 3) begin
          // Weight write and start during ACCUM must both be ignored.
          w_valid  = 1'b1;
          w_clause = 8'd5;
          w_class  = 3'd2;
          w_data   = 8'($signed(-100));
          start    = 1'b1;
          tick();
          w_valid  = 1'b0;
          start    = 1'b0;
          if (cv16 || cv8) early++;
        end
        repeat ($urandom_range(1, 3)) begin
          tick();
          if (cv16 || cv8) early++;
        end
      end
    end
    clause_done = 1'b0;
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL %s early_valid: got %0d strobes expected 0", name, early);
    end
    checks++;
    if (busy16 !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_argmax: got %b expected 1", name, busy16);
    end
    lat = 1;
    while (!cv16 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== NCS + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, NCS + 1);
    end
    checks++;
    if (cv8 !== 1'b1 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: got valid8=%b busy=%b expected 1/0", name, cv8, busy16);
    end
    checks++;
    if (int'(co16) !== ei16 || int'($signed(cs16)) !== es16) begin
      errors++;
      $display("FAIL %s result16: got class %0d sum %0d expected class %0d sum %0d",
               name, co16, $signed(cs16), ei16, es16);
    end
    checks++;
    if (int'(co8) !== ei8 || int'($signed(cs8)) !== es8) begin
      errors++;
      $display("FAIL %s result8: got class %0d sum %0d expected class %0d sum %0d",
               name, co8, $signed(cs8), ei8, es8);
    end
    // start during DONE must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (cv16 !== 1'b0 || busy16 !== 1'b0 || int'(co16) !== ei16 || int'($signed(cs16)) !== es16) begin
      errors++;
      $display("FAIL %s after_done: got valid=%b busy=%b class %0d sum %0d expected 0 0 %0d %0d",
               name, cv16, busy16, co16, $signed(cs16), ei16, es16);
    end
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; img_rst = 1'b0; start = 1'b0; w_valid = 1'b0;
    clause_done = 1'b0; clause_op = 1'b0;
    w_clause = '0; w_class = '0; w_data = '0;
    pulse_rst();
    checks++;
    if (busy16 !== 1'b0 || cv16 !== 1'b0 || co16 !== 3'd0 || cs16 !== 16'd0 ||
        busy8 !== 1'b0 || cv8 !== 1'b0 || co8 !== 3'd0 || cs8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b class=%0d sum=%0d expected all 0",
               busy16, cv16, co16, cs16);
    end
    run_inference("reset_zero_weights", 10'h3FF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ramp();
    for (int k = 0; k < NCL; k++)
      for (int c = 0; c < NCS; c++) write_w(k, c, c + 1);
    run_inference("ramp", 10'h3FF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ties();
    fill_w(5);
    run_inference("ties", 10'b00_0000_1001, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    fill_w(0);
    for (int k = 0; k < NCL; k++) write_w(k, 1, 127);
    run_inference("sat_pos", 10'h3FF, 0, 1'b0, 1'b0);
    fill_w(-128);
    for (int k = 0; k < NCL; k++) write_w(k, 3, -1);
    run_inference("sat_neg", 10'h3FF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_held_level();
    for (int k = 0; k < NCL; k++)
      for (int c = 0; c < NCS; c++) write_w(k, c, (k == 0) ? 40 : c);
    run_inference("held_level", 10'h3FF, 20, 1'b0, 1'b0);
  endtask

  task automatic test_start_edge();
    for (int k = 0; k < NCL; k++)
      for (int c = 0; c < NCS; c++) write_w(k, c, (k == 9 && c == 2) ? 90 : 1);
    run_inference("start_edge", 10'h3FF, 0, 1'b1, 1'b0);
  endtask

  task automatic test_accum_write();
    fill_w(3);
    write_w(5, 2, 9);
    run_inference("accum_write", 10'h3FF, 0, 1'b0, 1'b1);
  endtask

  task automatic test_bad_index();
    fill_w(0);
    write_w(2, 3, 1);
    write_w(10, 0, 50);
    write_w(16, 1, 60);
    write_w(0, 5, 70);
    write_w(1, 7, 80);
    write_w(255, 2, 90);
    run_inference("bad_index", 10'h3FF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_img_rst();
    logic [2:0]  p_co;
    logic [15:0] p_cs;
    int stray;
    for (int k = 0; k < NCL; k++)
      for (int c = 0; c < NCS; c++) write_w(k, c, (c == 4) ? 7 : k - c);
    p_co = co16;
    p_cs = cs16;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clause_done = 1'b1;
      clause_op = 1'b1;
      tick();
      clause_done = 1'b0;
      tick();
    end
    img_rst = 1'b1;
    clause_done = 1'b1;
    start = 1'b1;
    tick();
    img_rst = 1'b0;
    clause_done = 1'b0;
    start = 1'b0;
    checks++;
    if (busy16 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL img_rst_busy: got %b/%b expected 0", busy16, busy8);
    end
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      clause_done = i[0];
      tick();
      if (cv16 || cv8 || busy16) stray++;
    end
    clause_done = 1'b0;
    tick();
    checks++;
    if (stray !== 0 || co16 !== p_co || cs16 !== p_cs) begin
      errors++;
      $display("FAIL img_rst_hold: got stray=%0d class %0d sum %0d expected 0 %0d %0d",
               stray, co16, cs16, p_co, p_cs);
    end
    run_inference("img_rst_restart", 10'h3FF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NCL; k++)
        for (int c = 0; c < NCS; c++) write_w(k, c, $urandom_range(0, 255) - 128);
      run_inference("random", 10'($urandom), 0, 1'b0, 1'(i));
    end
  endtask

  task automatic test_back_to_back();
    fill_w(2);
    write_w(7, 3, 60);
    run_inference("b2b_first", 10'h3FF, 0, 1'b0, 1'b0);
    run_inference("b2b_second", 10'b00_0111_1111, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_clears();
    pulse_rst();
    checks++;
    if (co16 !== 3'd0 || cs16 !== 16'd0 || co8 !== 3'd0 || cs8 !== 8'd0) begin
      errors++;
      $display("FAIL rst_clears_result: got class %0d sum %0d expected 0 0", co16, cs16);
    end
    run_inference("rst_clears_weights", 10'h3FF, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_ties();
    test_saturation();
    test_held_level();
    test_start_edge();
    test_accum_write();
    test_bad_index();
    test_img_rst();
    test_random();
    test_back_to_back();
    test_reset_clears();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_vote_accum.md
CLAUSE_VOTE_ACCUM -- requirements
Module: clause_vote_accum

Interface
REQ-001 SHALL have parameter CLAUSEN, default 10, number of clauses per inference.
REQ-002 SHALL have parameter CLASSN, default 5, number of classes.
REQ-003 SHALL have parameter WEIGHT_W, default 8, signed two's-complement clause weight width.
REQ-004 SHALL have parameter SUM_W, default 16, signed class-sum width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port img_rst  input  1  per-image abort and clear; synchronous, active-high.
REQ-008 SHALL have port start  input  1  begin one inference; one-cycle pulse.
REQ-009 SHALL have port w_valid  input  1  weight write strobe.
REQ-010 SHALL have port w_clause  input  8  weight clause index.
REQ-011 SHALL have port w_class  input  3  weight class index.
REQ-012 SHALL have port w_data  input  WEIGHT_W  signed weight value.
REQ-013 SHALL have port clause_done  input  1  clause-evaluation done level from the convolution stage.
REQ-014 SHALL have port clause_op  input  1  clause fired (OR over all patches) from the convolution stage.
REQ-015 SHALL have port busy  output  1  high in ACCUM and ARGMAX.
REQ-016 SHALL have port class_valid  output  1  one-cycle result strobe.
REQ-017 SHALL have port class_out  output  3  winning class index.
REQ-018 SHALL have port class_sum  output  SUM_W  winning class sum, signed.

Function
REQ-019 SHALL store CLAUSEN x CLASSN weights in registers; a write occurs when w_valid=1 and the state is IDLE; writes with w_clause>=CLAUSEN or w_class>=CLASSN are dropped; writes in any other state are ignored.
REQ-020 SHALL implement FSM IDLE -> ACCUM -> ARGMAX -> DONE -> IDLE.
REQ-021 IDLE: start=1 SHALL clear all CLASSN sums and the clause counter and move to ACCUM next cycle; start in any other state is ignored.
REQ-022 ACCUM: a clause is accepted on a clause_done rising edge (clause_done=1 this cycle, 0 the previous cycle); clause_op is sampled in that same cycle; a level held high counts once.
REQ-023 On acceptance with clause_op=1, for every class c, sum[c] SHALL become sum[c] + sign-extended weight[cnt][c] in that cycle; clause_op=0 leaves the sums unchanged; cnt increments in both cases.
REQ-024 Additions SHALL saturate to the SUM_W signed limits: max 2^(SUM_W-1)-1, min -2^(SUM_W-1).
REQ-025 When the accepted clause is cnt=CLAUSEN-1, the FSM SHALL enter ARGMAX on the next cycle; clause_done edges in ARGMAX or DONE are ignored.
REQ-026 ARGMAX SHALL scan classes 0..CLASSN-1, one per cycle; best is initialised to class 0; the best index is replaced only on strictly greater, so ties resolve to the lowest index; the scan takes CLASSN cycles, then the FSM enters DONE.
REQ-027 DONE SHALL last one cycle with class_valid=1, class_out=best index and class_sum=best sum, then the FSM returns to IDLE.
REQ-028 class_out and class_sum SHALL hold their value until the next DONE.
REQ-029 Latency SHALL be CLASSN+1 cycles from the cycle accepting the final clause to the class_valid cycle.
REQ-030 busy SHALL be 1 exactly in ACCUM and ARGMAX.
REQ-031 If start=1 and a clause_done rising edge occur in the same IDLE cycle, the edge SHALL NOT be counted.

Reset
REQ-032 rst SHALL set state=IDLE, all weights=0, all sums=0, cnt=0, busy=0, class_valid=0, class_out=0, class_sum=0, and clear the clause_done edge history.
REQ-033 img_rst SHALL set state=IDLE, sums=0, cnt=0, class_valid=0 and clear the edge history; weights, class_out and class_sum are retained; an in-progress inference is aborted with no class_valid.
REQ-034 rst SHALL take priority over img_rst, and img_rst SHALL take priority over start, w_valid and clause_done in the same cycle.

Verification
REQ-035 Load weight[k][c] = c+1 for all k, start, 10 edges all with clause_op=1 -> sums 10,20,30,40,50; class_valid exactly 6 cycles after the 10th accept; class_out=4; class_sum=50.
REQ-036 Load weight[k][c] = 5 for all k and c, fire only clauses 0 and 3 -> every sum is 10; ties give class_out=0, class_sum=10.
REQ-037 Load weight[k][1] = 127 for all k, SUM_W=8, all clauses fire -> sum[1] saturates at 127; class_out=1.
REQ-038 Hold clause_done high for 20 cycles, plus 9 further clean pulses -> exactly 10 accepts; no early result.
REQ-039 img_rst after 4 accepts -> busy=0 next cycle, no class_valid, weights intact; restart produces the correct result.
REQ-040 w_valid during ACCUM with w_data=-100 -> weight unchanged; the result matches the pre-load value.
